// File: rtl/vlc_pkg.sv
// vlc_pkg: shared defaults, lane widths, histogram FSM states and bus region selects for video_line_capture
package vlc_pkg;
    localparam int PIX_W_DEF        = 12;
    localparam int LINE_PIXELS_DEF  = 1024;
    localparam int PIX_PER_WORD_DEF = 4;
    localparam int HISTO_BINS_DEF   = 512;
    localparam int CNT_W_DEF        = 27;
    localparam int BUS_W_DEF        = 64;
    localparam int ADDR_W_DEF       = 9;

    localparam int LINE_LANE_W  = 16;
    localparam int HISTO_LANE_W = 32;

    typedef logic [0:0] histo_state_t;
    localparam histo_state_t CLEAR = 1'b0;
    localparam histo_state_t RUN   = 1'b1;

    localparam logic REGION_LINE  = 1'b0;
    localparam logic REGION_HISTO = 1'b1;
endpackage

// File: rtl/vlc_histo_bank.sv
// vlc_histo_bank: ping-pong histogram RAM with a 3-stage read-modify-write pipeline and a bin-clear sequencer
//   clk, rst       clock, synchronous active-low reset
//   pix_valid      pixel strobe
//   pix_bin        bin index of the pixel
//   frame_end      vblank rising edge
//   rd_addr        bus word address (two bins per word)
//   rd_data        {bin[2w+1], bin[2w]} of the inactive bank, one cycle after rd_addr
//   which          bank readable by the bus
//   drop           pixel rejected this cycle (clearing or draining)
//   VLC_HISTO_SAT_EN: counters saturate instead of wrapping
module vlc_histo_bank
    import vlc_pkg::*;
#(
    parameter int HISTO_BINS = HISTO_BINS_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    localparam int BIN_W     = $clog2(HISTO_BINS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    input  logic [BIN_W-1:0]   pix_bin,
    input  logic               frame_end,
    input  logic [BIN_W-2:0]   rd_addr,
    output logic [2*CNT_W-1:0] rd_data,
    output logic               which,
    output logic               drop
);
    logic [CNT_W-1:0] mem [0:2*HISTO_BINS-1];
    histo_state_t st;
    logic bank, accept, v1, v2, v3;
    logic [1:0] drain;
    logic [BIN_W-1:0] clr, b1, b2, b3;
    logic [CNT_W-1:0] q1, n2, n3, base, inc;

    assign accept = pix_valid & (st == RUN) & (drain == 2'd0);
    assign drop   = pix_valid & ~accept;
    // q1 was read on the same edge that committed s3, so s3 must be forwarded as well as s2 (newest wins)
    assign base = (v2 && b2 == b1) ? n2 : (v3 && b3 == b1) ? n3 : q1;
`ifdef VLC_HISTO_SAT_EN
    assign inc = &base ? base : base + CNT_W'(1);
`else
    assign inc = base + CNT_W'(1);
`endif

    always_ff @(posedge clk) begin
        q1      <= mem[{bank, pix_bin}];
        rd_data <= {mem[{~bank, rd_addr, 1'b1}], mem[{~bank, rd_addr, 1'b0}]};
        if (st == CLEAR)
            mem[{bank, clr}] <= '0;
        else if (v2)
            mem[{bank, b2}] <= n2;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st    <= CLEAR;
            bank  <= 1'b0;
            which <= 1'b0;
            clr   <= '0;
            drain <= 2'd0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
        end else begin
            v1 <= accept;
            b1 <= pix_bin;
            v2 <= v1;
            b2 <= b1;
            n2 <= inc;
            v3 <= v2 & (st == RUN);
            b3 <= b2;
            n3 <= n2;
            if (st == CLEAR) begin
                clr <= clr + BIN_W'(1);
                if (&clr)
                    st <= RUN;
            end else if (drain == 2'd1) begin
                // the last accepted pixel commits to the old bank on this edge
                drain <= 2'd0;
                bank  <= ~bank;
                which <= bank;
                st    <= CLEAR;
            end else if (drain != 2'd0)
                drain <= drain - 2'd1;
            else if (frame_end)
                drain <= 2'd2;
        end
    end
endmodule

// File: rtl/video_line_capture.sv
// video_line_capture: ping-pong line and histogram capture on the camera path, completed banks readable over the video-memory bus
//   clk, rst                                  clock, synchronous active-low reset
//   vid_pixel, vid_pixsync, vid_visible       pixel input; valid when pixsync & visible
//   vid_hblank, vid_vblank                    rising edges end the line / frame
//   vm_bus_enable, vm_rw, vm_address          bus request (address MSB selects histogram)
//   vm_acknowledge, vm_read_data              ack and read data one cycle after the request
//   status_which_line, status_which_histo     completed banks
//   status_overflow                           sticky dropped-pixel flag
//   VLC_HISTO_SAT_EN: histogram counters saturate instead of wrapping
module video_line_capture
    import vlc_pkg::*;
#(
    parameter int PIX_W        = PIX_W_DEF,
    parameter int LINE_PIXELS  = LINE_PIXELS_DEF,
    parameter int PIX_PER_WORD = PIX_PER_WORD_DEF,
    parameter int HISTO_BINS   = HISTO_BINS_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int BUS_W        = BUS_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PIX_W-1:0]  vid_pixel,
    input  logic              vid_pixsync,
    input  logic              vid_hblank,
    input  logic              vid_vblank,
    input  logic              vid_visible,
    input  logic              vm_bus_enable,
    input  logic              vm_rw,
    input  logic [ADDR_W-1:0] vm_address,
    output logic              vm_acknowledge,
    output logic [BUS_W-1:0]  vm_read_data,
    output logic              status_which_line,
    output logic              status_which_histo,
    output logic              status_overflow
);
    localparam int LA    = $clog2(LINE_PIXELS);
    localparam int KB    = $clog2(PIX_PER_WORD);
    localparam int WA    = ADDR_W - 1;
    localparam int BIN_W = $clog2(HISTO_BINS);

    logic [PIX_W-1:0] line_mem [0:2*LINE_PIXELS-1];
    logic lb, hb_q, vb_q, pv, hb_rise, region_q, read_q, histo_drop;
    logic [LA:0] ptr;
    logic [BUS_W-1:0] line_word, line_q, histo_word;
    logic [2*CNT_W-1:0] histo_q;

    assign pv      = vid_pixsync & vid_visible;
    assign hb_rise = vid_hblank & ~hb_q;

    for (genvar k = 0; k < PIX_PER_WORD; k++) begin : g_line_lane
        assign line_word[k*LINE_LANE_W +: LINE_LANE_W] =
            {line_mem[{~lb, vm_address[WA-1:0], KB'(k)}], {(LINE_LANE_W-PIX_W){1'b0}}};
    end

    for (genvar k = 0; k < 2; k++) begin : g_histo_lane
        assign histo_word[k*HISTO_LANE_W +: HISTO_LANE_W] =
            {{(HISTO_LANE_W-CNT_W){1'b0}}, histo_q[k*CNT_W +: CNT_W]};
    end

    assign vm_read_data = (vm_acknowledge & read_q) ? (region_q == REGION_HISTO ? histo_word : line_q) : '0;

    vlc_histo_bank #(
        .HISTO_BINS (HISTO_BINS),
        .CNT_W      (CNT_W)
    ) u_histo (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pv),
        .pix_bin   (vid_pixel[PIX_W-1 -: BIN_W]),
        .frame_end (vid_vblank & ~vb_q),
        .rd_addr   (vm_address[WA-1:0]),
        .rd_data   (histo_q),
        .which     (status_which_histo),
        .drop      (histo_drop)
    );

    always_ff @(posedge clk) begin
        line_q <= line_word;
        if (pv && !ptr[LA])
            line_mem[{lb, ptr[LA-1:0]}] <= vid_pixel;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lb                <= 1'b0;
            ptr               <= '0;
            hb_q              <= 1'b0;
            vb_q              <= 1'b0;
            status_which_line <= 1'b0;
            status_overflow   <= 1'b0;
            vm_acknowledge    <= 1'b0;
            read_q            <= 1'b0;
            region_q          <= 1'b0;
        end else begin
            hb_q           <= vid_hblank;
            vb_q           <= vid_vblank;
            vm_acknowledge <= vm_bus_enable;
            read_q         <= vm_bus_enable & vm_rw;
            region_q       <= vm_address[ADDR_W-1];
            // a pixel on the hblank edge still lands in the old bank at the old pointer
            if (hb_rise) begin
                lb                <= ~lb;
                ptr               <= '0;
                status_which_line <= lb;
            end else if (pv && !ptr[LA])
                ptr <= ptr + (LA+1)'(1);
            if ((pv && ptr[LA]) || histo_drop)
                status_overflow <= 1'b1;
        end
    end
endmodule
